reg_file: RTL and testbench

- 32 x 32-bit general-purpose register file for the single-cycle CPU.
- Sits directly upstream of the ALU: read port RS drives ALU src1_i; read port RT drives ALU src2_i, or is bypassed by the immediate mux.
- ALU result_o, or load data, returns through the write port at the clock edge that ends the instruction.
- Two asynchronous read ports, one synchronous write port; register 0 hardwired to zero.

---
 rtl/reg_file.sv | 73 +++++++
 tb/tb_reg_file.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit general-purpose register file for the single-cycle CPU.
//
// Two asynchronous read ports (RS and RT) and one synchronous write port.
// Register 0 always reads as zero. A synchronous reset clears every register
// except the stack pointer (SP_IDX), which loads SP_INIT.
//
// Optional build macro: REG_FILE_BYPASS_EN
//   When defined, a write in progress (reg_write_i=1, rst_i=0, rd_addr_i!=0)
//   is forwarded combinationally to any read port that addresses the same
//   register. When undefined, reads return stored contents only.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous reset, active-high
//   rs_addr_i    read port A index
//   rt_addr_i    read port B index
//   rd_addr_i    write index
//   rd_data_i    write data
//   reg_write_i  write enable
//   rs_data_o    read port A data (ALU src1)
//   rt_data_o    read port B data (ALU src2 / store data)

module reg_file #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned SP_IDX  = 29,
    parameter int unsigned SP_INIT = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              reg_write_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [Depth];
    logic              wr_en;

    // Writes to register 0 are dropped so it never holds anything but zero.
    assign wr_en = reg_write_i && (rd_addr_i != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end
        end else if (wr_en) begin
            regs_q[rd_addr_i] <= rd_data_i;
        end
    end

    always_comb begin
        // Index 0 is forced to zero on the read side as well, so it is clean
        // even though the storage cell is never written.
        rs_data_o = (rs_addr_i == '0) ? '0 : regs_q[rs_addr_i];
        rt_data_o = (rt_addr_i == '0) ? '0 : regs_q[rt_addr_i];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && !rst_i && (rd_addr_i == rs_addr_i)) begin
            rs_data_o = rd_data_i;
        end
        if (wr_en && !rst_i && (rd_addr_i == rt_addr_i)) begin
            rt_data_o = rd_data_i;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        clk_i;
    logic        rst_i;
    logic [4:0]  rs_addr_i;
    logic [4:0]  rt_addr_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        reg_write_i;
    logic [31:0] rs_data_o;
    logic [31:0] rt_data_o;

    int errors = 0;
    int checks = 0;

    // Reference contents: plain array, updated from the behavioural rules.
    logic [31:0] model [32];

    reg_file dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rs_addr_i   (rs_addr_i),
        .rt_addr_i   (rt_addr_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_i   (rd_data_i),
        .reg_write_i (reg_write_i),
        .rs_data_o   (rs_data_o),
        .rt_data_o   (rt_data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REG_FILE_BYPASS_EN
        if (reg_write_i && !rst_i && rd_addr_i != 5'd0 && rd_addr_i == a) return rd_data_i;
`endif
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge with the current inputs, updating the model.
    task automatic step();
        if (rst_i) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            model[29] = 32'd128;
        end else if (reg_write_i && rd_addr_i != 5'd0) begin
            model[rd_addr_i] = rd_data_i;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        rd_addr_i   = a;
        rd_data_i   = d;
        reg_write_i = 1'b1;
        step();
        reg_write_i = 1'b0;
    endtask

    task automatic read_both(input string tag, input logic [4:0] a, input logic [4:0] b);
        rs_addr_i = a;
        rt_addr_i = b;
        #1;
        check({tag, "_rs"}, rs_data_o, exp_read(a));
        check({tag, "_rt"}, rt_data_o, exp_read(b));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        rst_i       = 1'b1;
        rs_addr_i   = 5'd0;
        rt_addr_i   = 5'd0;
        rd_addr_i   = 5'd3;
        rd_data_i   = 32'h99;
        reg_write_i = 1'b1;   // reset must win over this write
        @(negedge clk_i);
        step();
        rst_i       = 1'b0;
        reg_write_i = 1'b0;

        // Reset sweep: constant expectations straight from the reset rule.
        for (int i = 0; i < 32; i++) begin
            rs_addr_i = 5'(i);
            rt_addr_i = 5'(31 - i);
            #1;
            check("reset_rs", rs_data_o, (i == 29) ? 32'h80 : 32'h0);
            check("reset_rt", rt_data_o, ((31 - i) == 29) ? 32'h80 : 32'h0);
        end

        // Basic write/read.
        write(5'd5, 32'hDEADBEEF);
        rs_addr_i = 5'd5;
        rt_addr_i = 5'd5;
        #1;
        check("r5_rs", rs_data_o, 32'hDEADBEEF);
        check("r5_rt", rt_data_o, 32'hDEADBEEF);
        write(5'd31, 32'h12345678);
        rt_addr_i = 5'd31;
        #1;
        check("r31_rt", rt_data_o, 32'h12345678);
        check("r5_kept", rs_data_o, 32'hDEADBEEF);

        // Register 0 and write enable.
        write(5'd0, 32'hFFFFFFFF);
        rs_addr_i = 5'd0;
        #1;
        check("r0_zero", rs_data_o, 32'h0);
        rd_addr_i   = 5'd7;
        rd_data_i   = 32'hAAAA5555;
        reg_write_i = 1'b0;
        step();
        rt_addr_i = 5'd7;
        #1;
        check("r7_no_we", rt_data_o, 32'h0);

        // Same-cycle read and write of r9.
        write(5'd9, 32'h1);
        rs_addr_i   = 5'd9;
        rd_addr_i   = 5'd9;
        rd_data_i   = 32'h2;
        reg_write_i = 1'b1;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("r9_same_cycle", rs_data_o, 32'h2);
`else
        check("r9_same_cycle", rs_data_o, 32'h1);
`endif
        step();
        reg_write_i = 1'b0;
        #1;
        check("r9_after_edge", rs_data_o, 32'h2);

        // No forwarding to register 0.
        rs_addr_i   = 5'd0;
        rd_addr_i   = 5'd0;
        rd_data_i   = 32'h5;
        reg_write_i = 1'b1;
        #1;
        check("r0_no_bypass", rs_data_o, 32'h0);
        step();
        reg_write_i = 1'b0;

        // Reset mid-operation.
        write(5'd3, 32'h77);
        write(5'd29, 32'h40);
        read_both("pre_rst", 5'd3, 5'd29);
        rst_i       = 1'b1;
        rd_addr_i   = 5'd3;
        rd_data_i   = 32'h99;
        reg_write_i = 1'b1;
        step();
        rst_i       = 1'b0;
        reg_write_i = 1'b0;
        rs_addr_i   = 5'd3;
        rt_addr_i   = 5'd29;
        #1;
        check("rst_mid_r3", rs_data_o, 32'h0);
        check("rst_mid_r29", rt_data_o, 32'h80);
        write(5'd3, 32'h99);
        #1;
        check("post_rst_write", rs_data_o, 32'h99);

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst_i       = ($urandom_range(0, 40) == 0);
            reg_write_i = ($urandom_range(0, 3) != 0);
            rd_addr_i   = 5'($urandom_range(0, 31));
            rd_data_i   = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                rs_addr_i = rd_addr_i;
                rt_addr_i = 5'($urandom_range(0, 31));
            end else begin
                rs_addr_i = 5'($urandom_range(0, 31));
                rt_addr_i = ($urandom_range(0, 3) == 0) ? rd_addr_i : 5'($urandom_range(0, 31));
            end
            #1;
            check("rand_rs", rs_data_o, exp_read(rs_addr_i));
            check("rand_rt", rt_data_o, exp_read(rt_addr_i));
            step();
        end
        rst_i       = 1'b0;
        reg_write_i = 1'b0;
        for (int i = 0; i < 32; i++) read_both("final", 5'(i), 5'(i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
